// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner: per-slot dead time, leading-zero and
// per-digit blanking, and a double-buffered value that swaps only at frame end.
module display_scan_controller #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        enable,
    input  logic        loadValid,
    output logic        loadReady,
    input  logic [15:0] digitsIn,
    input  logic        lzEnable,
    input  logic [3:0]  blankMask,
    output logic [3:0]  anode,
    output logic [3:0]  digitCode,
    output logic        digitBlank,
    output logic        frameTick
);
    localparam int            CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pend_q, pend_d;
    logic          ready_q, ready_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    code_q, code_d;
    logic          blank_q, blank_d;
    logic          tick_q, tick_d;

    logic [3:0]    nib_zero;
    logic [3:0]    zero_upper;
    logic [3:0]    suppress;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign nib_zero[gi] = (active_d[4*gi +: 4] == 4'd0);
    end

    // zero_upper[i] is set when digit i and every digit above it are zero
    assign zero_upper = {nib_zero[3], &nib_zero[3:2], &nib_zero[3:1], &nib_zero[3:0]};
    assign suppress   = blankMask | ({4{lzEnable}} & zero_upper & 4'b1110);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CNT_SHOW) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A capture made during the frameTick cycle is not yet visible here, so it
    // naturally waits for the following frame end.
    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        ready_d  = ready_q;
        if (!ready_q && (tick_q || state_q == ST_IDLE)) begin
            active_d = pend_q;
            ready_d  = 1'b1;
        end else if (loadValid && ready_q) begin
            pend_d  = digitsIn;
            ready_d = 1'b0;
        end
    end

    // Outputs are decoded from next-state values so they register in step with the state.
    always_comb begin
        anode_d = 4'hf;
        code_d  = 4'd0;
        blank_d = 1'b1;
        if (state_d == ST_SHOW && !suppress[idx_d]) begin
            anode_d        = 4'hf;
            anode_d[idx_d] = 1'b0;
            code_d         = active_d[{idx_d, 2'b00} +: 4];
            blank_d        = 1'b0;
        end
        tick_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            ready_q  <= 1'b1;
            anode_q  <= 4'hf;
            code_q   <= 4'd0;
            blank_q  <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            anode_q  <= anode_d;
            code_q   <= code_d;
            blank_q  <= blank_d;
            tick_q   <= tick_d;
        end
    end

    assign loadReady  = ready_q;
    assign anode      = anode_q;
    assign digitCode  = code_q;
    assign digitBlank = blank_q;
    assign frameTick  = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: stimulus queues expected digit runs, frame ticks, ready
// rises and output snapshots; a monitor pops and compares as they appear.
module tb_display_scan_controller;
    localparam int PRESCALE     = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clock = 1'b0;
    logic        resetN;
    logic        enable;
    logic        loadValid;
    logic        loadReady;
    logic [15:0] digitsIn;
    logic        lzEnable;
    logic [3:0]  blankMask;
    logic [3:0]  anode;
    logic [3:0]  digitCode;
    logic        digitBlank;
    logic        frameTick;

    display_scan_controller #(
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .enable    (enable),
        .loadValid (loadValid),
        .loadReady (loadReady),
        .digitsIn  (digitsIn),
        .lzEnable  (lzEnable),
        .blankMask (blankMask),
        .anode     (anode),
        .digitCode (digitCode),
        .digitBlank(digitBlank),
        .frameTick (frameTick)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         start;
        logic [3:0] an;
        logic [3:0] code;
        int         len;
    } disp_t;

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [3:0] code;
        logic       blank;
        logic       tick;
        logic       ready;
    } snap_t;

    disp_t disp_q[$];
    snap_t snap_q[$];
    int    tick_q[$];
    int    rise_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic push_disp(input int s, input logic [3:0] an, input logic [3:0] code, input int len);
        disp_t d;
        d.start = s; d.an = an; d.code = code; d.len = len;
        disp_q.push_back(d);
    endtask

    task automatic push_snap(input int c, input logic [3:0] an, input logic [3:0] code,
                             input logic blank, input logic tick, input logic ready);
        snap_t s;
        s.c = c; s.an = an; s.code = code; s.blank = blank; s.tick = tick; s.ready = ready;
        snap_q.push_back(s);
    endtask

    // Full frame with all four digits visible, starting BLANK at cycle base.
    task automatic push_frame(input int base, input logic [15:0] val);
        logic [3:0] an;
        for (int k = 0; k < 4; k++) begin
            an    = 4'hf;
            an[k] = 1'b0;
            push_disp(base + PRESCALE * k + BLANK_CYCLES, an, val[4*k +: 4], PRESCALE - BLANK_CYCLES);
        end
        tick_q.push_back(base + 4 * PRESCALE - 1);
    endtask

    task automatic check_disp(input int s, input logic [8:0] sig, input int len);
        disp_t e;
        checks++;
        if (disp_q.size() == 0) begin
            failures++;
            $display("FAIL disp_unexpected: got start=%0d anode=%b code=%0d len=%0d, required no run",
                     s, sig[8:5], sig[4:1], len);
            return;
        end
        e = disp_q.pop_front();
        if (s != e.start || sig[8:5] != e.an || sig[4:1] != e.code || sig[0] != 1'b0 || len != e.len) begin
            failures++;
            $display("FAIL disp: got start=%0d anode=%b code=%0d blank=%b len=%0d, required start=%0d anode=%b code=%0d blank=0 len=%0d",
                     s, sig[8:5], sig[4:1], sig[0], len, e.start, e.an, e.code, e.len);
        end else begin
            $display("disp start=%0d anode=%b code=%0d len=%0d ok", s, e.an, e.code, len);
        end
    endtask

    task automatic check_event(input string name, inout int q[$], input int c);
        int e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected: got cycle=%0d, required none", name, c);
            return;
        end
        e = q.pop_front();
        if (c != e) begin
            failures++;
            $display("FAIL %s: got cycle=%0d, required cycle=%0d", name, c, e);
        end else begin
            $display("%s cycle=%0d ok", name, c);
        end
    endtask

    logic       run_act = 1'b0;
    int         run_start = 0;
    int         run_len = 0;
    logic [8:0] run_sig = '0;
    logic       prev_ready = 1'b0;

    task automatic monitor_step();
        logic [8:0] cur;
        snap_t      s;
        cur = {anode, digitCode, digitBlank};
        if (run_act && cur == run_sig) begin
            run_len++;
        end else begin
            if (run_act) check_disp(run_start, run_sig, run_len);
            if (anode != 4'hf) begin
                run_act = 1'b1; run_start = cyc; run_sig = cur; run_len = 1;
            end else begin
                run_act = 1'b0;
            end
        end
        if (frameTick) check_event("tick", tick_q, cyc);
        if (loadReady && !prev_ready) check_event("ready_rise", rise_q, cyc);
        while (snap_q.size() > 0 && snap_q[0].c < cyc) begin
            s = snap_q.pop_front();
            checks++;
            failures++;
            $display("FAIL snap_missed: got no sample at cycle=%0d, required one", s.c);
        end
        if (snap_q.size() > 0 && snap_q[0].c == cyc) begin
            s = snap_q.pop_front();
            checks++;
            if (anode != s.an || digitCode != s.code || digitBlank != s.blank ||
                frameTick != s.tick || loadReady != s.ready) begin
                failures++;
                $display("FAIL snap cycle=%0d: got anode=%b code=%0d blank=%b tick=%b ready=%b, required anode=%b code=%0d blank=%b tick=%b ready=%b",
                         cyc, anode, digitCode, digitBlank, frameTick, loadReady,
                         s.an, s.code, s.blank, s.tick, s.ready);
            end else begin
                $display("snap cycle=%0d anode=%b ready=%b ok", cyc, anode, loadReady);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 2) monitor_step();
            prev_ready = loadReady;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic leftover(input string name, input int n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL %s_leftover: got %0d unmatched expectations, required 0", name, n);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        enable    = 1'b0;
        loadValid = 1'b0;
        digitsIn  = 16'h0000;
        lzEnable  = 1'b1;
        blankMask = 4'b0000;
        @(negedge clock);

        // reset values, then a load while idle commits one cycle after capture
        wait_until(3);   push_snap(4, 4'hf, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_until(5);   resetN = 1'b1;
        wait_until(6);   push_snap(7, 4'hf, 4'd0, 1'b1, 1'b0, 1'b0);
                         rise_q.push_back(8);
                         digitsIn = 16'h1234; loadValid = 1'b1;
        wait_until(7);   loadValid = 1'b0;

        // basic scan of 0x1234
        wait_until(9);   push_frame(10, 16'h1234); enable = 1'b1;

        // mid-frame load during digit 1, shown from the next frame
        wait_until(22);  push_snap(23, 4'b1101, 4'd3, 1'b0, 1'b0, 1'b0);
                         rise_q.push_back(42);
                         push_frame(42, 16'h5678);
                         digitsIn = 16'h5678; loadValid = 1'b1;
        wait_until(23);  loadValid = 1'b0;

        // load coincident with frameTick waits a whole extra frame
        wait_until(73);  push_snap(74, 4'hf, 4'd0, 1'b1, 1'b0, 1'b0);
                         push_frame(74, 16'h5678);
                         rise_q.push_back(106);
                         digitsIn = 16'h0050; loadValid = 1'b1;
        wait_until(74);  loadValid = 1'b0;
                         push_disp(108, 4'b1110, 4'd0, 6);
                         push_disp(116, 4'b1101, 4'd5, 6);
                         tick_q.push_back(137);
                         push_snap(126, 4'hf, 4'd0, 1'b1, 1'b0, 1'b1);

        // forced blank of digit 0 on top of zero suppression
        wait_until(130); blankMask = 4'b0001;
                         push_snap(142, 4'hf, 4'd0, 1'b1, 1'b0, 1'b1);
                         push_disp(148, 4'b1101, 4'd5, 6);
                         tick_q.push_back(169);

        // enable drop at slot count 4 of digit 2
        wait_until(169); lzEnable = 1'b0; blankMask = 4'b0000;
                         push_disp(172, 4'b1110, 4'd0, 6);
                         push_disp(180, 4'b1101, 4'd5, 6);
                         push_disp(188, 4'b1011, 4'd0, 3);
                         push_snap(191, 4'hf, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_until(190); enable = 1'b0;
        wait_until(191); push_snap(192, 4'hf, 4'd0, 1'b1, 1'b0, 1'b0);
                         rise_q.push_back(193);
                         digitsIn = 16'h9087; loadValid = 1'b1;
        wait_until(192); loadValid = 1'b0;

        // re-enable restarts at digit 0; then reset mid-frame with a pending load
        wait_until(193); push_frame(194, 16'h9087);
                         push_disp(228, 4'b1110, 4'd7, 6);
                         push_disp(236, 4'b1101, 4'd8, 5);
                         push_snap(238, 4'b1101, 4'd8, 1'b0, 1'b0, 1'b0);
                         rise_q.push_back(241);
                         push_snap(241, 4'hf, 4'd0, 1'b1, 1'b0, 1'b1);
                         enable = 1'b1;
        wait_until(236); digitsIn = 16'h4321; loadValid = 1'b1;
        wait_until(237); loadValid = 1'b0;
        wait_until(240); resetN = 1'b0;
        wait_until(243); push_frame(244, 16'h0000); resetN = 1'b1;
        wait_until(276); enable = 1'b0;
        wait_until(282);

        leftover("disp", disp_q.size());
        leftover("tick", tick_q.size());
        leftover("ready_rise", rise_q.size());
        leftover("snap", snap_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
